// File: rtl/phy_pkg.sv
// Shared constants and state encoding for the byte serializer.
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_K = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_K  = 8'h7C;

  typedef enum logic {
    COMMA  = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/piso_shift8.sv
// 8-bit parallel-in serial-out shifter; MSB leaves first, a new byte enters every 8th edge.
module piso_shift8
  import phy_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BYTE_W-1:0] load_val_i,
  input  logic              load_en_i,
  output logic              load_edge_o,
  output logic              data_o
);
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        cont_q, cont_d;

  // Slot boundary: the edge on which cont wraps from 7 back to 0.
  assign load_edge_o = (cont_q == 3'd7);
  assign data_o      = shreg_q[BYTE_W-1];

  always_comb begin
    cont_d = cont_q + 3'd1;
    if (load_edge_o && load_en_i) begin
      shreg_d = load_val_i;
    end else begin
      shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cont_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      cont_q  <= cont_d;
    end
  end
endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte serializer: comma preamble after reset, then data or idle bytes per slot.
// Optional periodic comma insertion is enabled by defining PERIODIC_COMMA_EN.
module paralelo_serial_tx
  import phy_pkg::*;
#(
  parameter int COMMA_COUNT    = 4,
  parameter int COMMA_INTERVAL = 64
)(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              data_taken,
  output logic              active
);
  localparam int CCW = $clog2(COMMA_COUNT + 1);

  state_t            state_q, state_d;
  logic [CCW-1:0]    comma_cnt_q, comma_cnt_d;
  logic              active_q, active_d;
  logic              taken_q, taken_d;
  logic              load_edge;
  logic [BYTE_W-1:0] load_val;
  logic              periodic_slot;

`ifdef PERIODIC_COMMA_EN
  localparam int SCW = $clog2(COMMA_INTERVAL + 1);
  logic [SCW-1:0] slot_cnt_q, slot_cnt_d;

  assign periodic_slot = (slot_cnt_q == SCW'(COMMA_INTERVAL - 1));
`else
  assign periodic_slot = 1'b0;
`endif

  piso_shift8 u_shift (
    .clk_i       (clk_32f),
    .rst_i       (reset),
    .load_val_i  (load_val),
    .load_en_i   (load_edge),
    .load_edge_o (load_edge),
    .data_o      (data_out)
  );

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    active_d    = active_q;
    taken_d     = 1'b0;
    load_val    = IDLE_K;
`ifdef PERIODIC_COMMA_EN
    slot_cnt_d  = slot_cnt_q;
`endif
    if (load_edge) begin
      if (state_q == COMMA) begin
        load_val = COMMA_K;
        if (comma_cnt_q != CCW'(COMMA_COUNT)) begin
          comma_cnt_d = comma_cnt_q + CCW'(1);
        end
        if (comma_cnt_q == CCW'(COMMA_COUNT - 1)) begin
          state_d = ACTIVE;
        end
      end else begin
        active_d = 1'b1;
`ifdef PERIODIC_COMMA_EN
        slot_cnt_d = periodic_slot ? '0 : slot_cnt_q + SCW'(1);
`endif
        // A periodic comma steals the slot, so pending data waits one byte.
        if (periodic_slot) begin
          load_val = COMMA_K;
        end else if (valid_in) begin
          load_val = data_in;
          taken_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= COMMA;
      comma_cnt_q <= '0;
      active_q    <= 1'b0;
      taken_q     <= 1'b0;
`ifdef PERIODIC_COMMA_EN
      slot_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      active_q    <= active_d;
      taken_q     <= taken_d;
`ifdef PERIODIC_COMMA_EN
      slot_cnt_q  <= slot_cnt_d;
`endif
    end
  end

  assign data_taken = taken_q;
  assign active     = active_q;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: slot-level reference model plus directed tables.
module tb_paralelo_serial_tx;
  localparam int CC   = 4;
  localparam int CI   = 4;
  localparam int MAXS = 512;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out;
  logic       data_taken;
  logic       active;

  paralelo_serial_tx #(.COMMA_COUNT(CC), .COMMA_INTERVAL(CI)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .data_taken (data_taken),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  int         n_chk = 0;
  int         n_pass = 0;
  int         e = 0;
  logic [7:0] exp_slot [MAXS];
  bit         exp_tk   [MAXS];
  logic [7:0] obs_byte [MAXS];
  bit         obs_tk   [MAXS];
  logic [7:0] obs_sr = 8'h00;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] xb;
    logic       xt;
  } vec_t;

  vec_t tbl [6];
  int   ks  [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (edge %0d)", name, act, expv, e);
  endtask

  // Slot k counts load edges since reset release; slots 1..CC are the preamble.
  function automatic bit is_pc(input int k);
`ifdef PERIODIC_COMMA_EN
    return (k > CC) && ((k - CC) % CI == 0);
`else
    return (k < 0);
`endif
  endfunction

  function automatic logic exp_out_f();
    logic [7:0] b;
    if (e < 8) return 1'b0;
    b = exp_slot[(e - 8) / 8 + 1];
    return b[7 - ((e - 8) % 8)];
  endfunction

  task automatic step();
    int k;
    @(posedge clk_32f);
    e++;
    if (e % 8 == 0) begin
      k = e / 8;
      if (k <= CC || is_pc(k)) begin
        exp_slot[k] = 8'hBC; exp_tk[k] = 1'b0;
      end else if (valid_in) begin
        exp_slot[k] = data_in; exp_tk[k] = 1'b1;
      end else begin
        exp_slot[k] = 8'h7C; exp_tk[k] = 1'b0;
      end
    end
    #1;
    chk("data_out", 8'(data_out), 8'(exp_out_f()));
    chk("active", 8'(active), 8'(e / 8 >= CC + 1));
    chk("data_taken", 8'(data_taken), (e % 8 == 0) ? 8'(exp_tk[e / 8]) : 8'h00);
    obs_sr = {obs_sr[6:0], data_out};
    if (e % 8 == 0) obs_tk[e / 8] = data_taken;
    if (e >= 8 && (e - 8) % 8 == 7) begin
      k = (e - 8) / 8 + 1;
      obs_byte[k] = obs_sr;
      $display("slot %0d: byte %02h taken %0d", k, obs_sr, obs_tk[k]);
      chk("slot_byte", obs_byte[k], exp_slot[k]);
    end
  endtask

  task automatic apply_reset(input int hold);
    reset = 1'b1;
    #1;
    chk("rst_data_out", 8'(data_out), 8'h00);
    chk("rst_active", 8'(active), 8'h00);
    chk("rst_taken", 8'(data_taken), 8'h00);
    repeat (hold) @(posedge clk_32f);
    @(negedge clk_32f);
    reset  = 1'b0;
    e      = 0;
    obs_sr = 8'h00;
  endtask

  task automatic align(input int phase);
    while (e % 8 != phase) step();
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 8'hA5, 1'b1};
    tbl[1] = '{1'b1, 8'h01, 8'h01, 1'b1};
    tbl[2] = '{1'b1, 8'h80, 8'h80, 1'b1};
    tbl[3] = '{1'b0, 8'h55, 8'h7C, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
    tbl[5] = '{1'b1, 8'h00, 8'h00, 1'b1};

    // Power-up reset held 3 clocks, idle input: preamble then idles.
    apply_reset(3);
    repeat (39) step();
    chk("active_before_5th", 8'(active), 8'h00);
    step();
    chk("active_at_5th", 8'(active), 8'h01);
    for (int k = 1; k <= CC; k++) chk("preamble", obs_byte[k], 8'hBC);
    repeat (8) step();
    chk("first_idle", obs_byte[CC + 1], 8'h7C);

    // Directed slots: single byte, back-to-back bytes, idle gap.
    align(0);
    for (int i = 0; i < 6; i++) begin
      valid_in = tbl[i].v;
      data_in  = tbl[i].d;
      repeat (8) step();
      ks[i] = e / 8;
    end
    valid_in = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 6; i++) begin
      chk("tbl_byte", obs_byte[ks[i]], is_pc(ks[i]) ? 8'hBC : tbl[i].xb);
      chk("tbl_taken", 8'(obs_tk[ks[i]]), is_pc(ks[i]) ? 8'h00 : 8'(tbl[i].xt));
    end

    // valid_in raised mid-slot waits for the next load edge.
    align(3);
    valid_in = 1'b1;
    data_in  = 8'h3C;
    repeat (4) begin
      step();
      chk("late_valid_early", 8'(data_taken), 8'h00);
    end
    step();
    chk("late_valid_taken", 8'(data_taken), is_pc(e / 8) ? 8'h00 : 8'h01);
    valid_in = 1'b0;
    repeat (8) step();

    // Randomized upstream obeying the valid/taken handshake.
    repeat (480) begin
      step();
      if (valid_in && data_taken) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = 8'($urandom);
      end else if (!valid_in && $urandom_range(0, 3) == 0) begin
        valid_in = 1'b1;
        data_in  = 8'($urandom);
      end
    end

    // Continuously valid stream; periodic commas, when enabled, stall it.
    valid_in = 1'b1;
    data_in  = 8'($urandom);
    repeat (96) begin
      step();
      if (data_taken) data_in = 8'($urandom);
    end

    // Reset mid-data at cont==4 with a byte whose bits are all 1.
    valid_in = 1'b0;
    align(0);
    valid_in = 1'b1;
    data_in  = 8'hFF;
    repeat (8) step();
    valid_in = 1'b0;
    repeat (4) step();
    chk("pre_rst_out", 8'(data_out), is_pc(e / 8) ? 8'h00 : 8'h01);
    chk("pre_rst_active", 8'(active), 8'h01);
    #2;
    apply_reset(3);
    repeat (48) step();
    for (int k = 1; k <= CC; k++) chk("re_preamble", obs_byte[k], 8'hBC);
    chk("re_idle", obs_byte[CC + 1], 8'h7C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
